icon_channel_ctrl: RTL and testbench

Sequencing controller for one interconnect broadcast channel (`type_icon_channel`). It accepts one routing instruction (`type_icon_instr`) at a time and waits for the execution unit named by `src_addr.euidx` to present matching result data. It then drives that data onto the channel and holds it until every receiver in `receiver_list` has acknowledged. It sits between the front-end dispatch and the exec-unit/receiver fabric; one instance exists per interconnect channel.

---
 rtl/pkg_dtypes.sv | 54 +++++
 rtl/icon_ack_accumulator.sv | 29 ++
 rtl/icon_channel_ctrl.sv | 146 ++++++++++++++
 tb/tb_icon_channel_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_dtypes.sv
// Shared interconnect datatypes plus the channel-controller FSM encoding and defaults.
package pkg_dtypes;

  localparam int unsigned LOG2_NUM_EXEC_UNITS = 2;
  localparam int unsigned NUM_EXEC_UNITS      = 2 ** LOG2_NUM_EXEC_UNITS;
  localparam int unsigned ICON_UID_W          = 4;
  localparam int unsigned ICON_DATA_W         = 8;
  // One receiver per exec unit plus the store unit in the top bit.
  localparam int unsigned ICON_NUM_RECEIVERS  = NUM_EXEC_UNITS + 1;
  localparam int unsigned ICON_RCV_STR        = NUM_EXEC_UNITS;

  localparam int unsigned ICON_CHAN_TIMEOUT_CYCLES = 64;

  typedef logic [ICON_NUM_RECEIVERS-1:0] type_icon_receivers_list;

  typedef struct packed {
    logic [LOG2_NUM_EXEC_UNITS-1:0] euidx;
    logic [ICON_UID_W-1:0]          uid;
  } type_icon_src_addr;

  typedef struct packed {
    type_icon_src_addr       src_addr;
    type_icon_receivers_list receiver_list;
  } type_icon_instr;

  typedef struct packed {
    type_icon_src_addr       src_addr;
    type_icon_receivers_list receiver_list;
    logic [ICON_DATA_W-1:0]  data;
    logic                    data_valid;
    type_icon_receivers_list success_list;
  } type_icon_channel;

  typedef struct packed {
    logic                   req_valid;
    type_icon_src_addr      src_addr;
    logic [ICON_DATA_W-1:0] data;
    logic                   data_valid_tx;
  } type_icon_tx_channel_chside;

  typedef struct packed {
    logic                   success;
    logic [ICON_DATA_W-1:0] data_rx;
    logic                   data_valid_rx;
  } type_icon_rx_channel_chside;

  typedef enum logic [1:0] {
    StIdle,
    StWaitData,
    StBcast,
    StDone
  } enum_icon_chan_state;

endpackage

// File: rtl/icon_ack_accumulator.sv
// Sticky, receiver-masked OR of per-receiver acks plus the all-acknowledged compare.
module icon_ack_accumulator
  import pkg_dtypes::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    en,
  input  type_icon_receivers_list success_list,
  input  type_icon_receivers_list receiver_list,
  output type_icon_receivers_list acc,
  output logic                    all_acked
);

  type_icon_receivers_list acc_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q | (success_list & receiver_list);
    end
  end

  assign acc = acc_q;
  // Include this cycle's acks so completion is not delayed by the accumulator register.
  assign all_acked = ((acc_q | success_list) & receiver_list) == receiver_list;

endmodule

// File: rtl/icon_channel_ctrl.sv
// Broadcast sequencer for one interconnect channel: instruction -> wait for EU data -> hold until acked.
// Optional watchdog abort is built when ICON_CHAN_TIMEOUT_EN is defined.
module icon_channel_ctrl
  import pkg_dtypes::*;
#(
  parameter int unsigned NUM_EU         = 2 ** LOG2_NUM_EXEC_UNITS,
  parameter int unsigned TIMEOUT_CYCLES = ICON_CHAN_TIMEOUT_CYCLES
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  type_icon_instr             i_instr,
  input  logic                       i_instr_valid,
  output logic                       o_instr_ready,
  input  type_icon_tx_channel_chside i_eu_tx [NUM_EU],
  output type_icon_rx_channel_chside o_eu_rx [NUM_EU],
  input  type_icon_receivers_list    i_success_list,
  output type_icon_channel           o_chan,
  output logic                       o_busy,
  output logic                       o_abort
);

  enum_icon_chan_state        state_q, state_d;
  type_icon_instr             instr_q;
  logic [ICON_DATA_W-1:0]     data_q;
  logic                       chan_valid_q, busy_q, abort_q, abort_d;
  logic [NUM_EU-1:0]          success_q;
  type_icon_receivers_list    acc;
  logic                       all_acked, accept, match, timeout, in_bcast;
  type_icon_tx_channel_chside eu_tx_sel;

  // An out-of-range euidx selects nothing, so it can never match.
  always_comb begin
    eu_tx_sel = '0;
    for (int unsigned i = 0; i < NUM_EU; i++) begin
      if (32'(instr_q.src_addr.euidx) == i) eu_tx_sel = i_eu_tx[i];
    end
  end

  assign match = eu_tx_sel.req_valid && eu_tx_sel.data_valid_tx &&
                 (eu_tx_sel.src_addr == instr_q.src_addr);
  assign accept        = (state_q == StIdle) && i_instr_valid;
  assign in_bcast      = (state_q == StBcast);
  assign o_instr_ready = (state_q == StIdle);

  icon_ack_accumulator u_ack_acc (
    .clk          (i_clk),
    .reset        (i_reset),
    .clear        (accept),
    .en           (in_bcast),
    .success_list (i_success_list),
    .receiver_list(instr_q.receiver_list),
    .acc          (acc),
    .all_acked    (all_acked)
  );

`ifdef ICON_CHAN_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset || state_q == StIdle) begin
      cnt_q <= '0;
    end else if (state_q == StWaitData || state_q == StBcast) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign timeout = (32'(cnt_q) >= TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
    unique case (state_q)
      StIdle: if (i_instr_valid) state_d = StWaitData;
      StWaitData: begin
        if (match) begin
          state_d = StBcast;
        end else if (timeout) begin
          state_d = StIdle;
          abort_d = 1'b1;
        end
      end
      StBcast: begin
        if (all_acked) begin
          state_d = StDone;
        end else if (timeout) begin
          state_d = StIdle;
          abort_d = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= StIdle;
      instr_q      <= '0;
      data_q       <= '0;
      chan_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      abort_q      <= 1'b0;
      success_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) instr_q <= i_instr;
      if (state_q == StWaitData && match) data_q <= eu_tx_sel.data;
      chan_valid_q <= (state_d == StBcast);
      busy_q       <= (state_d != StIdle);
      abort_q      <= abort_d;
      for (int unsigned i = 0; i < NUM_EU; i++) begin
        success_q[i] <= (state_d == StDone) && (32'(instr_q.src_addr.euidx) == i);
      end
    end
  end

  always_comb begin
    o_chan = '0;
    if (chan_valid_q) begin
      o_chan.src_addr      = instr_q.src_addr;
      o_chan.receiver_list = instr_q.receiver_list;
      o_chan.data          = data_q;
      o_chan.data_valid    = 1'b1;
      o_chan.success_list  = acc;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_EU; i++) begin
      o_eu_rx[i]               = '0;
      o_eu_rx[i].success       = success_q[i];
      o_eu_rx[i].data_valid_rx = success_q[i];
      if (success_q[i]) o_eu_rx[i].data_rx = data_q;
    end
  end

  assign o_busy  = busy_q;
  assign o_abort = abort_q;

endmodule

// File: tb/tb_icon_channel_ctrl.sv
// Directed bench for icon_channel_ctrl; watchdog scenario follows ICON_CHAN_TIMEOUT_EN.
module tb_icon_channel_ctrl;
  import pkg_dtypes::*;

  localparam int unsigned NUM_EU  = 4;
  localparam int unsigned TIMEOUT = 8;

  logic                       clk = 1'b0;
  logic                       reset;
  type_icon_instr             instr;
  logic                       instr_valid;
  logic                       instr_ready;
  type_icon_tx_channel_chside eu_tx [NUM_EU];
  type_icon_rx_channel_chside eu_rx [NUM_EU];
  type_icon_receivers_list    succ;
  type_icon_channel           chan;
  logic                       busy, abort;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  icon_channel_ctrl #(
    .NUM_EU        (NUM_EU),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_instr       (instr),
    .i_instr_valid (instr_valid),
    .o_instr_ready (instr_ready),
    .i_eu_tx       (eu_tx),
    .o_eu_rx       (eu_rx),
    .i_success_list(succ),
    .o_chan        (chan),
    .o_busy        (busy),
    .o_abort       (abort)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_EU-1:0] pulses();
    logic [NUM_EU-1:0] r;
    for (int i = 0; i < NUM_EU; i++) r[i] = eu_rx[i].success;
    return r;
  endfunction

  function automatic logic rx_any();
    logic r = 1'b0;
    for (int i = 0; i < NUM_EU; i++) r = r | (|eu_rx[i]);
    return r;
  endfunction

  function automatic type_icon_instr mk_instr(input int e, input int uid,
                                              input type_icon_receivers_list rl);
    type_icon_instr r;
    r.src_addr.euidx = LOG2_NUM_EXEC_UNITS'(e);
    r.src_addr.uid   = ICON_UID_W'(uid);
    r.receiver_list  = rl;
    return r;
  endfunction

  function automatic type_icon_tx_channel_chside mk_tx(input int e, input int uid,
                                                       input logic [7:0] d);
    type_icon_tx_channel_chside r;
    r.req_valid      = 1'b1;
    r.src_addr.euidx = LOG2_NUM_EXEC_UNITS'(e);
    r.src_addr.uid   = ICON_UID_W'(uid);
    r.data           = d;
    r.data_valid_tx  = 1'b1;
    return r;
  endfunction

  task automatic clear_tx();
    for (int i = 0; i < NUM_EU; i++) eu_tx[i] = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr = '0; instr_valid = 1'b0; succ = '0; clear_tx();
    tick(); tick();
    reset = 1'b0;
    tick();
    n_total++; if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", instr_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (abort !== 1'b0) $display("FAIL reset_abort: got %b want 0", abort); else n_pass++;
    n_total++; if (chan !== '0) $display("FAIL reset_chan: got %h want 0", chan); else n_pass++;
    n_total++; if (rx_any() !== 1'b0) $display("FAIL reset_eu_rx: got %b want 0", rx_any()); else n_pass++;
  endtask

  task automatic test_basic();
    type_icon_receivers_list rl = '0;
    type_icon_channel exp_chan;
    type_icon_rx_channel_chside exp_rx;
    rl[0] = 1'b1; rl[ICON_RCV_STR] = 1'b1;
    instr = mk_instr(2, 5, rl); instr_valid = 1'b1;
    tick();  // accept edge; now T+1
    instr_valid = 1'b0;
    n_total++; if (busy !== 1'b1 || instr_ready !== 1'b0)
      $display("FAIL basic_wait: busy=%b ready=%b want 1/0", busy, instr_ready); else n_pass++;
    n_total++; if (chan.data_valid !== 1'b0) $display("FAIL basic_early_dv: got %b want 0", chan.data_valid); else n_pass++;
    eu_tx[2] = mk_tx(2, 5, 8'hA5);
    tick();  // T+2
    clear_tx();
    exp_chan = '0;
    exp_chan.src_addr = instr.src_addr; exp_chan.receiver_list = rl;
    exp_chan.data = 8'hA5; exp_chan.data_valid = 1'b1;
    n_total++; if (chan !== exp_chan) $display("FAIL basic_chan: got %h want %h", chan, exp_chan); else n_pass++;
    succ = rl;
    tick();  // T+3
    succ = '0;
    exp_rx.success = 1'b1; exp_rx.data_rx = 8'hA5; exp_rx.data_valid_rx = 1'b1;
    n_total++; if (eu_rx[2] !== exp_rx) $display("FAIL basic_rx2: got %h want %h", eu_rx[2], exp_rx); else n_pass++;
    n_total++; if (pulses() !== 4'b0100) $display("FAIL basic_pulses: got %b want 0100", pulses()); else n_pass++;
    n_total++; if (chan !== '0) $display("FAIL basic_chan_drop: got %h want 0", chan); else n_pass++;
    n_total++; if (instr_ready !== 1'b0) $display("FAIL basic_ready_t3: got %b want 0", instr_ready); else n_pass++;
    tick();  // T+4
    n_total++; if (instr_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL basic_ready_t4: ready=%b busy=%b want 1/0", instr_ready, busy); else n_pass++;
    n_total++; if (pulses() !== 4'b0000) $display("FAIL basic_pulse_len: got %b want 0000", pulses()); else n_pass++;
  endtask

  task automatic test_sticky();
    type_icon_receivers_list rl = '0;
    rl[0] = 1'b1; rl[ICON_RCV_STR] = 1'b1;
    instr = mk_instr(2, 5, rl); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; eu_tx[2] = mk_tx(2, 5, 8'h5C);
    tick();  // BCAST+0
    clear_tx();
    succ = 5'b00011;  // eu1 is not a listed receiver and must be masked
    tick();  // BCAST+1
    succ = '0;
    n_total++; if (chan.success_list !== 5'b00001) $display("FAIL sticky_list1: got %b want 00001", chan.success_list); else n_pass++;
    tick();  // BCAST+2
    n_total++; if (chan.success_list !== 5'b00001) $display("FAIL sticky_list2: got %b want 00001", chan.success_list); else n_pass++;
    tick();  // BCAST+3
    n_total++; if (busy !== 1'b1 || pulses() !== 4'b0000 || chan.data_valid !== 1'b1)
      $display("FAIL sticky_hold: busy=%b pulses=%b dv=%b want 1/0000/1", busy, pulses(), chan.data_valid); else n_pass++;
    succ = 5'b10000;
    tick();  // BCAST+4
    succ = '0;
    n_total++; if (pulses() !== 4'b0100 || eu_rx[2].data_rx !== 8'h5C)
      $display("FAIL sticky_done: pulses=%b data=%h want 0100/5c", pulses(), eu_rx[2].data_rx); else n_pass++;
    tick();
  endtask

  task automatic test_ignore();
    type_icon_instr ins;
    type_icon_receivers_list rl = 5'b00001;
    ins = mk_instr(2, 5, rl);
    instr = ins; instr_valid = 1'b1;
    tick();
    instr = mk_instr(3, 7, 5'b01000);  // held while busy; must not be taken
    eu_tx[1] = mk_tx(2, 5, 8'h11);
    eu_tx[3] = mk_tx(2, 5, 8'h33);
    eu_tx[2] = mk_tx(2, 6, 8'h22);
    succ = 5'b11111;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++; if (chan !== '0) $display("FAIL ignore_chan%0d: got %h want 0", i, chan); else n_pass++;
      n_total++; if (pulses() !== 4'b0000) $display("FAIL ignore_pulse%0d: got %b want 0000", i, pulses()); else n_pass++;
    end
    eu_tx[2] = mk_tx(2, 5, 8'h44);
    eu_tx[2].data_valid_tx = 1'b0;
    tick();
    n_total++; if (chan !== '0) $display("FAIL ignore_nodv: got %h want 0", chan); else n_pass++;
    instr_valid = 1'b0;
    eu_tx[2] = mk_tx(2, 5, 8'h5A);
    tick();
    clear_tx();
    n_total++; if (chan.src_addr !== ins.src_addr || chan.data !== 8'h5A || chan.receiver_list !== rl)
      $display("FAIL ignore_bcast: addr=%h data=%h rl=%b want %h/5a/%b",
               chan.src_addr, chan.data, chan.receiver_list, ins.src_addr, rl); else n_pass++;
    tick();
    succ = '0;
    n_total++; if (pulses() !== 4'b0100) $display("FAIL ignore_done: got %b want 0100", pulses()); else n_pass++;
    tick();
  endtask

  task automatic test_empty_list();
    instr = mk_instr(1, 3, '0); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; eu_tx[1] = mk_tx(1, 3, 8'h3C);
    tick();
    clear_tx();
    n_total++; if (chan.data_valid !== 1'b1 || chan.receiver_list !== '0)
      $display("FAIL empty_bcast: dv=%b rl=%b want 1/00000", chan.data_valid, chan.receiver_list); else n_pass++;
    tick();
    n_total++; if (pulses() !== 4'b0010 || eu_rx[1].data_rx !== 8'h3C || chan.data_valid !== 1'b0)
      $display("FAIL empty_done: pulses=%b data=%h dv=%b want 0010/3c/0",
               pulses(), eu_rx[1].data_rx, chan.data_valid); else n_pass++;
    tick();
    n_total++; if (instr_ready !== 1'b1) $display("FAIL empty_ready: got %b want 1", instr_ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    type_icon_receivers_list rl = 5'b10000;
    instr = mk_instr(0, 9, rl); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; eu_tx[0] = mk_tx(0, 9, 8'hC3);
    tick();
    clear_tx();
    n_total++; if (chan.data_valid !== 1'b1) $display("FAIL rmid_bcast: got %b want 1", chan.data_valid); else n_pass++;
    reset = 1'b1; succ = rl;
    tick();
    n_total++; if (chan !== '0 || rx_any() !== 1'b0 || busy !== 1'b0 || abort !== 1'b0)
      $display("FAIL rmid_clear: chan=%h rx=%b busy=%b abort=%b want 0", chan, rx_any(), busy, abort); else n_pass++;
    reset = 1'b0; succ = '0;
    tick();
    n_total++; if (instr_ready !== 1'b1 || pulses() !== 4'b0000)
      $display("FAIL rmid_after: ready=%b pulses=%b want 1/0000", instr_ready, pulses()); else n_pass++;
    tick();
    n_total++; if (pulses() !== 4'b0000) $display("FAIL rmid_nopulse: got %b want 0000", pulses()); else n_pass++;
  endtask

  task automatic test_timeout();
    instr = mk_instr(3, 1, 5'b00001); instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; eu_tx[3] = mk_tx(3, 1, 8'h77);
`ifdef ICON_CHAN_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      tick();
      clear_tx();
      n_total++; if (abort !== 1'b0 || chan.data_valid !== 1'b1)
        $display("FAIL to_wait%0d: abort=%b dv=%b want 0/1", i, abort, chan.data_valid); else n_pass++;
    end
    tick();
    n_total++; if (abort !== 1'b1 || chan !== '0 || busy !== 1'b0 || pulses() !== 4'b0000)
      $display("FAIL to_abort: abort=%b chan=%h busy=%b pulses=%b want 1/0/0/0000",
               abort, chan, busy, pulses()); else n_pass++;
    tick();
    n_total++; if (abort !== 1'b0 || instr_ready !== 1'b1)
      $display("FAIL to_after: abort=%b ready=%b want 0/1", abort, instr_ready); else n_pass++;
`else
    tick();
    clear_tx();
    repeat (100) tick();
    n_total++; if (busy !== 1'b1 || chan.data_valid !== 1'b1 || abort !== 1'b0 || pulses() !== 4'b0000)
      $display("FAIL to_hold: busy=%b dv=%b abort=%b pulses=%b want 1/1/0/0000",
               busy, chan.data_valid, abort, pulses()); else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    n_total++; if (instr_ready !== 1'b1) $display("FAIL to_recover: got %b want 1", instr_ready); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sticky();
    test_ignore();
    test_empty_list();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
